// File: rtl/uram_rk_pkg.sv
// Shared types and constants for the Simon128/256 round-key URAM port sequencer.
package uram_rk_pkg;

  typedef logic [0:0] req_idx_t;

  localparam int URAM_ADDR_W = 23;
  localparam int URAM_BWE_W  = 9;
  localparam logic [URAM_BWE_W-1:0] BWE_ALL = 9'h1FF;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/uram_rd_tag_pipe.sv
// Delay line that carries the requester index of each accepted read so the
// response can be steered back once the URAM data appears.
module uram_rd_tag_pipe
  import uram_rk_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_vld,
  input  req_idx_t push_idx,
  output logic     pop_vld,
  output req_idx_t pop_idx
);

  logic [STAGES-1:0] vld_p;
  req_idx_t          idx_p [STAGES];

  // Valid bits shift every cycle; reset flushes any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= push_vld;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Requester indices ride alongside the valid bits; only meaningful where valid is set.
  always_ff @(posedge clk) begin
    idx_p[0] <= push_idx;
    for (int i = 1; i < STAGES; i++) begin
      idx_p[i] <= idx_p[i-1];
    end
  end

  assign pop_vld = vld_p[STAGES-1];
  assign pop_idx = idx_p[STAGES-1];

endmodule

// File: rtl/uram_rk_arbiter.sv
// Sequences URAM port A for the round-key store: zero-fills the memory after
// reset, then shares the port between the key-expansion writer (requester 0)
// and the encrypt-core reader (requester 1) with round-robin fairness.
module uram_rk_arbiter
  import uram_rk_pkg::*;
#(
  parameter int NUM_WORDS      = 4096,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 72,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst_async,
  output logic                         init_done,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [1:0]                   req_we,
  input  logic [1:0][ADDR_W-1:0]       req_addr,
  input  logic [1:0][DATA_W-1:0]       req_wdata,
  output logic [1:0]                   rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         uram_en,
  output logic                         uram_we,
  output logic [URAM_ADDR_W-1:0]       uram_addr,
  output logic [DATA_W-1:0]            uram_din,
  output logic [URAM_BWE_W-1:0]        uram_bwe,
  input  logic [DATA_W-1:0]            uram_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  req_idx_t          rr_ptr;

  logic              gnt_any;
  req_idx_t          gnt_idx;
  logic              clr_last;
  logic              rd_push;
  logic              tag_vld;
  req_idx_t          tag_idx;

  assign clr_last = (state == CLEAR) && (clr_cnt == LAST_ADDR);

  // Pick the requester to serve this cycle; rr_ptr only breaks ties.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    if (state == SERVE) begin
      unique case (req_valid)
        2'b01: begin
          gnt_any = 1'b1;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          gnt_any = 1'b1;
          gnt_idx = 1'b1;
        end
        2'b11: begin
          gnt_any = 1'b1;
          gnt_idx = rr_ptr;
        end
        default: begin
          gnt_any = 1'b0;
        end
      endcase
    end
  end

  assign req_ready = gnt_any ? (2'b01 << gnt_idx) : 2'b00;

  // Drive the URAM port from either the clear sweep or the granted request.
  always_comb begin
    uram_en   = 1'b0;
    uram_we   = 1'b0;
    uram_addr = '0;
    uram_din  = '0;
    uram_bwe  = '0;
    if (state == CLEAR) begin
      uram_en   = 1'b1;
      uram_we   = 1'b1;
      uram_addr = URAM_ADDR_W'(clr_cnt);
      uram_bwe  = BWE_ALL;
    end else if (gnt_any) begin
      uram_en   = 1'b1;
      uram_we   = req_we[gnt_idx];
      uram_addr = URAM_ADDR_W'(req_addr[gnt_idx]);
      uram_din  = req_wdata[gnt_idx];
      uram_bwe  = req_we[gnt_idx] ? BWE_ALL : '0;
    end
  end

  // Clear/serve sequencing, round-robin pointer and the registered init flag.
  always_ff @(posedge clk) begin
    if (rst_async) begin
      state     <= RST_STATE;
      clr_cnt   <= '0;
      rr_ptr    <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= (state == SERVE) || clr_last;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_last) begin
          state <= SERVE;
        end
      end
      if (gnt_any) begin
        rr_ptr <= ~gnt_idx;
      end
    end
  end

  assign rd_push = gnt_any & ~req_we[gnt_idx];

  uram_rd_tag_pipe #(
    .STAGES (RD_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst_async),
    .push_vld (rd_push),
    .push_idx (gnt_idx),
    .pop_vld  (tag_vld),
    .pop_idx  (tag_idx)
  );

  // Steer the returning URAM word to whichever requester issued the read.
  always_comb begin
    rsp_valid = 2'b00;
    if (tag_vld) begin
      rsp_valid[tag_idx] = 1'b1;
    end
  end

  assign rsp_rdata = uram_dout;

endmodule

// File: tb/tb_uram_rk_arbiter.sv
// Bench for uram_rk_arbiter: a small clearing instance with read latency 1
// checked by a transaction-level scoreboard, plus a latency-2 no-clear instance.
module tb_uram_rk_arbiter;

  localparam int NW = 16;
  localparam int AW = 12;
  localparam int DW = 72;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- instance A: clear on reset, latency 1
  logic                rst_a;
  logic                a_init;
  logic [1:0]          a_vld, a_rdy, a_we, a_rv;
  logic [1:0][AW-1:0]  a_addr;
  logic [1:0][DW-1:0]  a_wd;
  logic [DW-1:0]       a_rd, a_din, a_dout;
  logic                a_en, a_uwe;
  logic [22:0]         a_uaddr;
  logic [8:0]          a_bwe;

  uram_rk_arbiter #(
    .NUM_WORDS(NW), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst_async(rst_a), .init_done(a_init),
    .req_valid(a_vld), .req_ready(a_rdy), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wd),
    .rsp_valid(a_rv), .rsp_rdata(a_rd),
    .uram_en(a_en), .uram_we(a_uwe), .uram_addr(a_uaddr), .uram_din(a_din), .uram_bwe(a_bwe),
    .uram_dout(a_dout)
  );

  // ---------------- instance B: no clear, latency 2
  logic                rst_b;
  logic                b_init;
  logic [1:0]          b_vld, b_rdy, b_we, b_rv;
  logic [1:0][AW-1:0]  b_addr;
  logic [1:0][DW-1:0]  b_wd;
  logic [DW-1:0]       b_rd, b_din, b_dout, b_d1;
  logic                b_en, b_uwe;
  logic [22:0]         b_uaddr;
  logic [8:0]          b_bwe;

  uram_rk_arbiter #(
    .NUM_WORDS(NW), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clk(clk), .rst_async(rst_b), .init_done(b_init),
    .req_valid(b_vld), .req_ready(b_rdy), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wd),
    .rsp_valid(b_rv), .rsp_rdata(b_rd),
    .uram_en(b_en), .uram_we(b_uwe), .uram_addr(b_uaddr), .uram_din(b_din), .uram_bwe(b_bwe),
    .uram_dout(b_dout)
  );

  // ---------------- URAM port models (never-written words read back as junk)
  function automatic logic [DW-1:0] junk(input logic [11:0] a);
    return {8'hEE, 52'h5A5A_5A5A_5A5A_5, a};
  endfunction

  logic [DW-1:0] mem_a [4096];
  logic          wr_a  [4096];
  logic [DW-1:0] mem_b [4096];
  logic          wr_b  [4096];

  always @(posedge clk) begin
    if (a_en) begin
      if (a_uwe) begin
        for (int b = 0; b < 9; b++)
          if (a_bwe[b]) mem_a[a_uaddr[11:0]][b*8 +: 8] <= a_din[b*8 +: 8];
        wr_a[a_uaddr[11:0]] <= 1'b1;
      end else begin
        a_dout <= (wr_a[a_uaddr[11:0]] === 1'b1) ? mem_a[a_uaddr[11:0]] : junk(a_uaddr[11:0]);
      end
    end
  end

  always @(posedge clk) begin
    if (b_en) begin
      if (b_uwe) begin
        for (int b = 0; b < 9; b++)
          if (b_bwe[b]) mem_b[b_uaddr[11:0]][b*8 +: 8] <= b_din[b*8 +: 8];
        wr_b[b_uaddr[11:0]] <= 1'b1;
      end else begin
        b_d1 <= (wr_b[b_uaddr[11:0]] === 1'b1) ? mem_b[b_uaddr[11:0]] : junk(b_uaddr[11:0]);
      end
    end
    b_dout <= b_d1;
  end

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // ---------------- scoreboard for instance A
  typedef struct {
    logic          idx;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] sh [4096];
  logic          mdl_on = 1'b0;
  logic          last_g = 1'b1;
  logic [1:0]    acc = 2'b00;
  int            cyc = 0;
  logic          m_g;
  logic [1:0]    m_er;
  exp_t          m_e;

  // Transaction model: who should win, what the port must show, what comes back and when.
  always @(negedge clk) begin
    if (rst_a) begin
      q.delete();
      last_g = 1'b1;
      acc    = 2'b00;
      for (int k = 0; k < NW; k++) sh[k] = '0;
    end else if (mdl_on) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        m_e = q.pop_front();
        chk("rsp_valid", a_rv, m_e.idx ? 2'b10 : 2'b01);
        chk("rsp_rdata", a_rd, m_e.data);
      end else begin
        chk("rsp_idle", a_rv, 2'b00);
      end
      if (a_vld == 2'b11) m_g = ~last_g;
      else                m_g = a_vld[1];
      m_er = (a_vld == 2'b00) ? 2'b00 : (m_g ? 2'b10 : 2'b01);
      chk("grant", a_rdy, m_er);
      chk("uram_en", a_en, a_vld != 2'b00);
      if (a_vld != 2'b00) begin
        chk("uram_we", a_uwe, a_we[m_g]);
        chk("uram_addr", a_uaddr, {11'b0, a_addr[m_g]});
        if (a_we[m_g]) begin
          chk("uram_din", a_din, a_wd[m_g]);
          chk("uram_bwe", a_bwe, 9'h1FF);
          sh[a_addr[m_g]] = a_wd[m_g];
        end else begin
          chk("uram_bwe_rd", a_bwe, 9'h000);
          q.push_back('{idx: m_g, data: sh[a_addr[m_g]], due: cyc + 1});
        end
        last_g = m_g;
      end
      acc = m_er;
    end else begin
      acc = 2'b00;
    end
    cyc++;
  end

  // Sweep of n clear cycles on instance A; a full sweep must end with init_done high.
  task automatic check_clear(input int n);
    for (int c = 0; c < n; c++) begin
      sample();
      chk("clear_cycle", {a_en, a_uwe, a_uaddr, a_bwe, a_din, a_rdy, a_rv, a_init},
          {1'b1, 1'b1, 23'(c), 9'h1FF, 72'h0, 2'b00, 2'b00, 1'b0});
      next();
    end
    if (n == NW) begin
      a_vld  = 2'b00;
      mdl_on = 1'b1;
      sample();
      chk("init_done_rise", a_init, 1'b1);
      next();
    end
  endtask

  typedef struct {
    logic [1:0] vld;
    logic [1:0] rdy;
  } vec_t;

  vec_t          tbl [12];
  int            i0, i1, k;
  logic [1:0]    pend;
  logic [95:0]   rnd;
  logic [DW-1:0] bv [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_vld = '0; a_we = '0; a_addr = '0; a_wd = '0;
    b_vld = '0; b_we = '0; b_addr = '0; b_wd = '0;
    pend  = '0;

    // ---- reset + full clear, requesters holding reads that must not be granted
    next(); next();
    rst_a = 1'b0;
    a_vld = 2'b11; a_addr[0] = 12'd0; a_addr[1] = 12'd9;
    check_clear(NW);

    // ---- every word reads back as zero
    for (int a = 0; a < NW; a++) begin
      a_vld = 2'b10; a_addr[1] = AW'(a);
      sample(); next();
    end
    a_vld = 2'b00; sample(); next();

    // ---- table-driven arbitration (requesters hold until accepted)
    tbl[0]  = '{2'b11, 2'b01}; tbl[1]  = '{2'b11, 2'b10}; tbl[2]  = '{2'b01, 2'b01};
    tbl[3]  = '{2'b00, 2'b00}; tbl[4]  = '{2'b10, 2'b10}; tbl[5]  = '{2'b11, 2'b01};
    tbl[6]  = '{2'b11, 2'b10}; tbl[7]  = '{2'b01, 2'b01}; tbl[8]  = '{2'b01, 2'b01};
    tbl[9]  = '{2'b11, 2'b10}; tbl[10] = '{2'b01, 2'b01}; tbl[11] = '{2'b10, 2'b10};
    a_we = 2'b00; a_addr[0] = 12'd2; a_addr[1] = 12'd9;
    for (int i = 0; i < 12; i++) begin
      a_vld = tbl[i].vld;
      sample();
      chk("tbl_ready", a_rdy, tbl[i].rdy);
      next();
    end
    a_vld = 2'b00; sample(); next();

    // ---- write then read of addr 5, response one cycle after the accept
    a_vld = 2'b01; a_we = 2'b01; a_addr[0] = 12'd5; a_wd[0] = 72'hAB_0123456789ABCDEF;
    sample(); next();
    a_vld = 2'b10; a_we = 2'b00; a_addr[1] = 12'd5;
    sample(); chk("lat_accept", a_rdy, 2'b10); next();
    a_vld = 2'b00;
    sample();
    chk("lat_rsp_valid", a_rv, 2'b10);
    chk("lat_rsp_data", a_rd, 72'hAB_0123456789ABCDEF);
    next();

    // ---- contention: six reads each, grants must alternate
    i0 = 0; i1 = 0; k = 0; a_we = 2'b00;
    while ((i0 < 6 || i1 < 6) && k < 20) begin
      a_vld = {i1 < 6, i0 < 6};
      a_addr[0] = AW'(i0); a_addr[1] = AW'(10 + i1);
      sample();
      if (k < 12) chk("cont_grant", a_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (acc[0]) i0++;
      if (acc[1]) i1++;
      k++;
      next();
    end
    chk("cont_cycles", k, 12);
    a_vld = 2'b00; sample(); next();

    // ---- fairness after idle
    a_vld = 2'b10; a_addr[1] = 12'd3;
    sample(); chk("fair_solo", a_rdy, 2'b10); next();
    a_vld = 2'b11; a_addr[0] = 12'd4; a_addr[1] = 12'd7;
    sample(); chk("fair_after_idle", a_rdy, 2'b01); next();
    a_vld = 2'b10;
    sample(); chk("fair_held", a_rdy, 2'b10); next();
    a_vld = 2'b00; sample(); next();

    // ---- address beyond NUM_WORDS passes straight through
    a_vld = 2'b01; a_we = 2'b01; a_addr[0] = 12'hABC; a_wd[0] = 72'h12_3456789A_BCDEF012;
    sample(); chk("pass_addr", a_uaddr, 23'hABC); next();
    a_vld = 2'b10; a_we = 2'b00; a_addr[1] = 12'hABC;
    sample(); next();
    a_vld = 2'b00; sample(); next();

    // ---- randomized traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          pend[r]   = 1'b1;
          a_we[r]   = $urandom_range(0, 1) == 1;
          a_addr[r] = AW'($urandom_range(0, NW - 1));
          rnd       = {$urandom, $urandom, $urandom};
          a_wd[r]   = rnd[DW-1:0];
        end
      end
      a_vld = pend;
      sample();
      if (acc[0]) pend[0] = 1'b0;
      if (acc[1]) pend[1] = 1'b0;
      next();
    end
    a_vld = 2'b00;
    for (int c = 0; c < 3; c++) begin sample(); next(); end
    chk("drain", q.size(), 0);

    // ---- reset with a read accepted on the reset edge, then reset mid-clear
    mdl_on = 1'b0;
    a_vld = 2'b01; a_we = 2'b00; a_addr[0] = 12'd0;
    rst_a = 1'b1;
    sample(); next();
    rst_a = 1'b0; a_vld = 2'b00;
    check_clear(7);
    rst_a = 1'b1;
    sample(); chk("midclr_addr", a_uaddr, 23'd7); next();
    rst_a = 1'b0;
    check_clear(NW);
    a_vld = 2'b10; a_addr[1] = 12'd5;
    sample(); next();
    a_vld = 2'b00; sample(); next();
    mdl_on = 1'b0;

    // ---- instance B: latency 2, no clear
    rst_b = 1'b1; next();
    rst_b = 1'b0;
    sample(); chk("b_init_in_reset_cycle", b_init, 1'b0); next();
    sample(); chk("b_init_after_reset", b_init, 1'b1);

    bv[3] = 72'h33_CAFEF00D_DEADBEEF;
    b_vld = 2'b10; b_we = 2'b10; b_addr[1] = 12'd3; b_wd[1] = bv[3];
    sample(); chk("b_wr_ready", b_rdy, 2'b10); next();
    b_vld = 2'b01; b_we = 2'b00; b_addr[0] = 12'd3;
    sample(); chk("b_rd_ready", b_rdy, 2'b01); next();
    b_vld = 2'b00;
    sample(); chk("b_lat2_early", b_rv, 2'b00); next();
    sample(); chk("b_lat2_valid", b_rv, 2'b01); chk("b_lat2_data", b_rd, bv[3]); next();
    sample(); chk("b_lat2_after", b_rv, 2'b00); next();

    bv[1] = 72'h11_0000_1111_2222_3333;
    bv[2] = 72'h22_4444_5555_6666_7777;
    for (int j = 1; j <= 2; j++) begin
      b_vld = 2'b01; b_we = 2'b01; b_addr[0] = AW'(j); b_wd[0] = bv[j];
      sample(); next();
    end
    b_we = 2'b00;
    for (int j = 0; j < 5; j++) begin
      b_vld = (j < 3) ? 2'b10 : 2'b00;
      b_addr[1] = AW'(j < 3 ? j + 1 : 3);
      sample();
      if (j >= 2) begin
        chk("b_b2b_valid", b_rv, 2'b10);
        chk("b_b2b_data", b_rd, bv[j-1]);
      end else begin
        chk("b_b2b_wait", b_rv, 2'b00);
      end
      next();
    end
    sample(); chk("b_b2b_end", b_rv, 2'b00); next();

    b_vld = 2'b01; b_addr[0] = 12'd2;
    sample(); next();
    b_vld = 2'b00; rst_b = 1'b1;
    sample(); next();
    rst_b = 1'b0;
    sample(); chk("b_rst_flush", b_rv, 2'b00); next();
    sample(); chk("b_rst_flush2", b_rv, 2'b00); next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uram_rk_arbiter.md
Name: uram_rk_arbiter

Overview:
- Sequences one URAM288 port (port A of uram_wrapper) for the Simon128/256 round-key store.
- Shares the port between two requesters: requester 0 is the key-expansion writer, requester 1 is the encrypt-core reader.
- After reset it clears the memory, then grants one access per cycle with round-robin fairness.
- Routes read data back to the requester that issued the read, after the URAM read latency.

Parameters:
- NUM_WORDS, 4096: number of 72-bit words cleared and addressed.
- ADDR_W, 12: requester address width; must satisfy 2**ADDR_W >= NUM_WORDS.
- DATA_W, 72: URAM word width.
- RD_LATENCY, 1: cycles from the accept edge to read data valid; 1 for OREG FALSE, 2 for OREG TRUE.
- CLEAR_ON_RESET, 1: 1 = zero-fill the memory after reset; 0 = go straight to SERVE.

Ports:
- clk  in  1  clock.
- rst_async  in  1  reset; synchronous, active-high.
- init_done  out  1  high once the clear sequence has finished.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester grant; at most one bit set.
- req_we  in  2  per-requester write (1) or read (0).
- req_addr  in  2x ADDR_W  per-requester word address.
- req_wdata  in  2x DATA_W  per-requester write data.
- rsp_valid  out  2  one-hot read response valid.
- rsp_rdata  out  DATA_W  read data, shared by both requesters.
- uram_en  out  1  to URAM EN_A.
- uram_we  out  1  to URAM RDB_WR_A.
- uram_addr  out  23  to URAM ADDR_A; req_addr zero-extended.
- uram_din  out  DATA_W  to URAM DIN_A.
- uram_bwe  out  9  to URAM BWE_A; 9'h1FF for every write, 0 for reads.
- uram_dout  in  DATA_W  from URAM DOUT_A.

Behaviour:
- Reset (synchronous):
  - init_done=0, rsp_valid=0, rr_ptr=0, clr_cnt=0, read-tag pipe flushed.
  - State goes to CLEAR if CLEAR_ON_RESET=1, otherwise SERVE.
- URAM-side outputs are combinational from the state and arbitration. uram_en=0 whenever nothing is issued.
- CLEAR state:
  - Each cycle: uram_en=1, uram_we=1, uram_addr=clr_cnt, uram_din=0, uram_bwe=9'h1FF; clr_cnt increments.
  - After the write with clr_cnt==NUM_WORDS-1, go to SERVE.
  - Clear takes exactly NUM_WORDS cycles. req_ready=0 throughout.
- SERVE state:
  - init_done=1 (registered, so it first rises the cycle after the last clear write).
  - Arbitration:
    - Only one requester valid: it is granted.
    - Both valid: grant requester rr_ptr.
    - After any grant, rr_ptr becomes the index of the other requester.
    - No valid: rr_ptr holds.
  - req_ready is combinational, and req_ready[i] may depend on req_valid[i].
  - Requester rule: a requester holds valid, we, addr and wdata stable until it is accepted.
  - Accept = req_valid[i] & req_ready[i]. On accept: uram_en=1, uram_we=req_we[i], uram_addr=req_addr[i], uram_din=req_wdata[i].
- Read response:
  - Each accepted read pushes a tag {valid, i} into a RD_LATENCY-deep shift pipe.
  - Exactly RD_LATENCY cycles after the accept edge: rsp_valid[i]=1 for one cycle, rsp_rdata=uram_dout.
  - rsp_rdata is don't-care when rsp_valid=0.
  - Writes produce no response.
- Throughput: one access per cycle. Back-to-back reads give back-to-back responses in issue order.
- Write then read to the same address on consecutive cycles: the read returns the new data.
- Addresses >= NUM_WORDS are passed through unchanged; no error flag.
- Reset mid-CLEAR or mid-SERVE: in-flight read tags are discarded with no rsp_valid, and clearing restarts at address 0.

Decomposition:
- Package uram_rk_pkg holds:
  - typedef req_idx_t (logic [0:0]);
  - localparam URAM_ADDR_W=23, URAM_BWE_W=9, BWE_ALL=9'h1FF;
  - enum state_t {CLEAR, SERVE}.
- One natural sub-module: uram_rd_tag_pipe (RD_LATENCY-deep tag shift register with synchronous flush).

Test Plan:
- Clear: NUM_WORDS=16, reset, then read addresses 0..15 -> init_done rises on cycle 17 after reset release; every rsp_rdata=72'h0.
- Latency: req0 writes 72'hAB_0123456789ABCDEF at addr 5, then req1 reads addr 5 -> rsp_valid=2'b10 exactly 1 cycle after the read accept; data matches.
- Contention: both requesters hold valid for 6 reads (req0 addrs 0..5, req1 addrs 10..15) -> grants alternate 0,1,0,1,...; responses one-hot and in issue order.
- Fairness after idle: req1 alone accepted once, then both valid -> req0 granted next.
- Reset mid-clear (clr_cnt=7) and mid-read (tag in flight) -> no rsp_valid; clear restarts at address 0; init_done stays 0 until NUM_WORDS cycles later.
- RD_LATENCY=2, CLEAR_ON_RESET=0: init_done=1 the cycle after reset; read of addr 3 -> rsp_valid 2 cycles after accept; three back-to-back reads -> three consecutive responses.
